// File: rtl/burst_ctrl.sv
// Burst/interrupter sequencer: ON gate bursts, ring-down tail, OFF gap, latched overcurrent fault.
// Optional in-burst parameter sweep toward par_end is enabled by defining BURST_SWEEP_EN.
module burst_ctrl #(
  parameter int CLK_MHZ       = 100,
  parameter int GEN_PARAMETER = 255,
  parameter int SWEEP_DIV     = 64,
  parameter int TAIL_CYCLES   = 200,
  localparam int PW = $clog2(GEN_PARAMETER + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          ocd,
  input  logic [7:0]    on_us,
  input  logic [15:0]   off_us,
  input  logic [PW-1:0] par_start,
  input  logic [PW-1:0] par_end,
  output logic          gen_en,
  output logic [PW-1:0] gen_inp,
  output logic          gate,
  output logic          busy,
  output logic          fault
);

  localparam int CNT_MAX = ((65535 * CLK_MHZ) > TAIL_CYCLES) ? (65535 * CLK_MHZ) : TAIL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(SWEEP_DIV + 1);

  localparam logic [CW-1:0] CLK_K     = CW'(CLK_MHZ);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] TAIL_LOAD = CW'(TAIL_CYCLES - 1);
  localparam logic [PW-1:0] PAR_MAX   = PW'(GEN_PARAMETER);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON    = 3'd1,
    TAIL  = 3'd2,
    OFF   = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] off_load_r;
  logic          launch_s;

  // A zero-microsecond interval collapses to a single-cycle dwell instead of wrapping.
  function automatic logic [CW-1:0] us_to_load(input logic [15:0] us);
    logic [CW-1:0] prod;
    prod = CW'(us) * CLK_K;
    if (prod == CNT_ZERO) begin
      us_to_load = CNT_ZERO;
    end else begin
      us_to_load = prod - CNT_ONE;
    end
  endfunction

  // Clamp to GEN_PARAMETER using the borrow of a widened subtraction.
  function automatic logic [PW-1:0] sat_par(input logic [PW-1:0] v);
    logic [PW:0] room;
    room    = {1'b0, PAR_MAX} - {1'b0, v};
    sat_par = room[PW] ? PAR_MAX : v;
  endfunction

`ifdef BURST_SWEEP_EN
  localparam logic [SW-1:0] SWEEP_LOAD = SW'(SWEEP_DIV - 1);
  localparam logic [SW-1:0] SWEEP_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] SWEEP_ONE  = SW'(1'b1);
  logic [PW-1:0] par_end_r;
  logic [SW-1:0] sweep_cnt_r;
`else
  logic unused_s;
  assign unused_s = ^par_end;
`endif

  // A burst starts from IDLE, or back-to-back from the last OFF cycle, when armed with a nonzero on-time.
  always_comb begin
    launch_s = 1'b0;
    if (arm && (on_us != 8'd0)) begin
      if (state_r == IDLE) begin
        launch_s = 1'b1;
      end else if ((state_r == OFF) && (cnt_r == CNT_ZERO)) begin
        launch_s = 1'b1;
      end else begin
        launch_s = 1'b0;
      end
    end else begin
      launch_s = 1'b0;
    end
  end

  // Sequencer state, dwell counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      off_load_r <= CNT_ZERO;
      gen_en     <= 1'b0;
      gen_inp    <= {PW{1'b0}};
      gate       <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
`ifdef BURST_SWEEP_EN
      par_end_r   <= {PW{1'b0}};
      sweep_cnt_r <= {SW{1'b0}};
`endif
    end else begin
      gen_en <= 1'b0;
      if (ocd) begin
        state_r <= FAULT;
        gate    <= 1'b0;
        busy    <= 1'b1;
        fault   <= 1'b1;
      end else if (launch_s) begin
        state_r    <= ON;
        gate       <= 1'b1;
        busy       <= 1'b1;
        gen_en     <= 1'b1;
        gen_inp    <= sat_par(par_start);
        cnt_r      <= us_to_load({8'd0, on_us});
        off_load_r <= us_to_load(off_us);
`ifdef BURST_SWEEP_EN
        par_end_r   <= sat_par(par_end);
        sweep_cnt_r <= SWEEP_LOAD;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            gate <= 1'b0;
            busy <= 1'b0;
          end
          ON: begin
            if (cnt_r == CNT_ZERO) begin
              state_r <= TAIL;
              gate    <= 1'b0;
              cnt_r   <= TAIL_LOAD;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
`ifdef BURST_SWEEP_EN
              // Steps only land on cycles that stay in ON, so TAIL never sees a new value.
              if (sweep_cnt_r == SWEEP_ZERO) begin
                sweep_cnt_r <= SWEEP_LOAD;
                if (gen_inp != par_end_r) begin
                  gen_inp <= (gen_inp > par_end_r) ? (gen_inp - PW'(1'b1)) : (gen_inp + PW'(1'b1));
                  gen_en  <= 1'b1;
                end
              end else begin
                sweep_cnt_r <= sweep_cnt_r - SWEEP_ONE;
              end
`endif
            end
          end
          TAIL: begin
            if (cnt_r == CNT_ZERO) begin
              state_r <= OFF;
              cnt_r   <= off_load_r;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          OFF: begin
            if (cnt_r == CNT_ZERO) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          FAULT: begin
            gate <= 1'b0;
            if (!arm) begin
              state_r <= IDLE;
              fault   <= 1'b0;
              busy    <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            gate    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
